// File: rtl/wb_arbiter.sv
// Writeback arbiter and load scoreboard: drives the register-file write port,
// merging ALU results with in-order load responses and tracking busy registers.
module wb_arbiter #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int MAX_LD = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alu_valid,
    input  logic [AW-1:0]               alu_rd,
    input  logic [XLEN-1:0]             alu_data,
    input  logic                        ld_issue_valid,
    input  logic [AW-1:0]               ld_issue_rd,
    output logic                        ld_issue_ready,
    input  logic                        ld_resp_valid,
    input  logic [XLEN-1:0]             ld_resp_data,
    output logic                        ld_resp_ready,
    input  logic [AW-1:0]               dec_rs1,
    input  logic [AW-1:0]               dec_rs2,
    input  logic [AW-1:0]               dec_rd,
    output logic                        dec_hazard,
    output logic                        wb_wen,
    output logic [AW-1:0]               wb_rd,
    output logic [XLEN-1:0]             wb_wdata,
    output logic [$clog2(MAX_LD):0]     ld_cnt,
    output logic                        err
);
    localparam int PW   = $clog2(MAX_LD);
    localparam int CW   = PW + 1;
    localparam int NREG = 2 ** AW;

    // Handshakes: a transfer happens on a cycle where valid && ready are both
    // high; ready never depends on the same channel's valid. The ALU channel
    // has no ready and always wins the write port over load responses.

    logic [NREG-1:0] busy, busy_next;
    logic [AW-1:0]   fifo [MAX_LD];
    logic [PW-1:0]   head, tail;
    logic [CW-1:0]   cnt, cnt_next;
    logic            err_next;

    logic            full, empty;
    logic            issue_fire, resp_fire;
    logic [AW-1:0]   head_rd;

    logic            sel_valid;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;

    assign full    = (cnt == CW'(MAX_LD));
    assign empty   = (cnt == '0);
    assign head_rd = fifo[head];

    assign ld_issue_ready = !full && !busy[ld_issue_rd];
    assign ld_resp_ready  = !alu_valid && !empty;
    assign issue_fire     = ld_issue_valid && ld_issue_ready;
    assign resp_fire      = ld_resp_valid && ld_resp_ready;

    // Hazard sees only registered state; a clear landing this cycle is not bypassed.
    assign dec_hazard = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd];

    assign ld_cnt = cnt;

    always_comb begin
        cnt_next = cnt;
        if (issue_fire && !resp_fire)
            cnt_next = cnt + CW'(1);
        else if (resp_fire && !issue_fire)
            cnt_next = cnt - CW'(1);
    end

    // Issue to a busy rd is blocked, so set and clear never collide on one bit.
    always_comb begin
        busy_next = busy;
        if (resp_fire)
            busy_next[head_rd] = 1'b0;
        if (issue_fire)
            busy_next[ld_issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_comb begin
        err_next = err;
        if (ld_issue_valid && !ld_issue_ready)
            err_next = 1'b1;
        if (ld_resp_valid && empty)
            err_next = 1'b1;
        if (alu_valid && busy[alu_rd])
            err_next = 1'b1;
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_data  = alu_data;
        end else if (resp_fire) begin
            sel_valid = 1'b1;
            sel_rd    = head_rd;
            sel_data  = ld_resp_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            err  <= 1'b0;
        end else begin
            busy <= busy_next;
            cnt  <= cnt_next;
            err  <= err_next;
            if (issue_fire)
                tail <= tail + PW'(1);
            if (resp_fire)
                head <= head + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_LD; i++)
                fifo[i] <= '0;
        end else if (issue_fire) begin
            fifo[tail] <= ld_issue_rd;
        end
    end

    // x0 writes still move wb_rd/wb_wdata; only the enable is suppressed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_wen   <= 1'b0;
            wb_rd    <= '0;
            wb_wdata <= '0;
        end else begin
            wb_wen <= sel_valid && (sel_rd != '0);
            if (sel_valid) begin
                wb_rd    <= sel_rd;
                wb_wdata <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: ALU path, load scoreboard, collisions,
// FIFO ordering/full, protocol violations and asynchronous reset.
module tb_wb_arbiter;
    localparam int XLEN   = 32;
    localparam int AW     = 5;
    localparam int MAX_LD = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            ld_issue_valid;
    logic [AW-1:0]   ld_issue_rd;
    logic            ld_issue_ready;
    logic            ld_resp_valid;
    logic [XLEN-1:0] ld_resp_data;
    logic            ld_resp_ready;
    logic [AW-1:0]   dec_rs1, dec_rs2, dec_rd;
    logic            dec_hazard;
    logic            wb_wen;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_wdata;
    logic [$clog2(MAX_LD):0] ld_cnt;
    logic            err;

    int passed = 0;
    int total  = 0;

    wb_arbiter #(.XLEN(XLEN), .AW(AW), .MAX_LD(MAX_LD)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_issue_valid(ld_issue_valid), .ld_issue_rd(ld_issue_rd),
        .ld_issue_ready(ld_issue_ready),
        .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
        .ld_resp_ready(ld_resp_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_hazard(dec_hazard),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
        .ld_cnt(ld_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid      = 1'b0;
        alu_rd         = '0;
        alu_data       = '0;
        ld_issue_valid = 1'b0;
        ld_issue_rd    = '0;
        ld_resp_valid  = 1'b0;
        ld_resp_data   = '0;
        dec_rs1        = '0;
        dec_rs2        = '0;
        dec_rd         = '0;
    endtask

    task automatic issue(input logic [AW-1:0] rd);
        ld_issue_valid = 1'b1;
        ld_issue_rd    = rd;
        tick();
        ld_issue_valid = 1'b0;
    endtask

    initial begin
        // Reset held with random activity on every input.
        rst = 1'b0;
        idle();
        for (int i = 0; i < 4; i++) begin
            alu_valid      = 1'($urandom_range(0, 1));
            alu_rd         = AW'($urandom_range(0, 31));
            alu_data       = $urandom;
            ld_issue_valid = 1'($urandom_range(0, 1));
            ld_issue_rd    = AW'($urandom_range(0, 31));
            ld_resp_valid  = 1'($urandom_range(0, 1));
            ld_resp_data   = $urandom;
            dec_rs1        = AW'($urandom_range(0, 31));
            dec_rs2        = AW'($urandom_range(0, 31));
            dec_rd         = AW'($urandom_range(0, 31));
            tick();
        end
        chk("rst_wen", wb_wen, 0);
        chk("rst_cnt", ld_cnt, 0);
        chk("rst_hazard", dec_hazard, 0);
        chk("rst_err", err, 0);
        chk("rst_rd", wb_rd, 0);
        chk("rst_wdata", wb_wdata, 0);
        idle();
        #3 rst = 1'b1;
        tick();
        tick();
        chk("post_rst_wen", wb_wen, 0);
        chk("post_rst_cnt", ld_cnt, 0);
        chk("post_rst_err", err, 0);
        chk("post_rst_issue_ready", ld_issue_ready, 1);
        chk("post_rst_resp_ready", ld_resp_ready, 0);

        // ALU path.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        chk("alu_wen", wb_wen, 1);
        chk("alu_rd", wb_rd, 5);
        chk("alu_wdata", wb_wdata, 32'hDEADBEEF);
        alu_rd = 5'd0; alu_data = 32'h0000_0055;
        tick();
        alu_valid = 1'b0;
        chk("alu_x0_wen", wb_wen, 0);
        chk("alu_x0_wdata", wb_wdata, 32'h55);
        tick();
        chk("idle_wen", wb_wen, 0);
        chk("idle_wdata_hold", wb_wdata, 32'h55);

        // Load scoreboard.
        issue(5'd7);
        chk("ld7_cnt", ld_cnt, 1);
        dec_rs1 = 5'd7; #1;
        chk("ld7_haz_rs1", dec_hazard, 1);
        dec_rs1 = 5'd0; dec_rd = 5'd7; #1;
        chk("ld7_haz_rd", dec_hazard, 1);
        dec_rd = 5'd8; #1;
        chk("ld7_no_haz", dec_hazard, 0);
        dec_rs1 = 5'd7;
        ld_resp_valid = 1'b1; ld_resp_data = 32'h12345678; #1;
        chk("ld7_resp_ready", ld_resp_ready, 1);
        chk("ld7_haz_same_cycle", dec_hazard, 1);
        tick();
        ld_resp_valid = 1'b0;
        chk("ld7_wen", wb_wen, 1);
        chk("ld7_rd", wb_rd, 7);
        chk("ld7_wdata", wb_wdata, 32'h12345678);
        chk("ld7_cnt0", ld_cnt, 0);
        chk("ld7_haz_clear", dec_hazard, 0);
        dec_rs1 = 5'd0; dec_rd = 5'd0;

        // ALU and load response collide; ALU wins, load follows.
        issue(5'd9);
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1;
        ld_resp_valid = 1'b1; ld_resp_data = 32'h0000CAFE; #1;
        chk("col_resp_ready", ld_resp_ready, 0);
        tick();
        alu_valid = 1'b0; #1;
        chk("col_alu_rd", wb_rd, 3);
        chk("col_alu_wdata", wb_wdata, 32'h1);
        chk("col_cnt", ld_cnt, 1);
        chk("col_resp_ready2", ld_resp_ready, 1);
        tick();
        ld_resp_valid = 1'b0;
        chk("col_ld_wen", wb_wen, 1);
        chk("col_ld_rd", wb_rd, 9);
        chk("col_ld_wdata", wb_wdata, 32'hCAFE);
        chk("col_cnt0", ld_cnt, 0);

        // Fill to MAX_LD, then drain in order with one issue+response overlap.
        issue(5'd1); issue(5'd2); issue(5'd3); issue(5'd4);
        chk("full_cnt", ld_cnt, 4);
        ld_issue_rd = 5'd6; ld_resp_valid = 1'b1; ld_resp_data = 32'hAAAA0001; #1;
        chk("full_issue_ready", ld_issue_ready, 0);
        tick();
        chk("full_w1_rd", wb_rd, 1);
        chk("full_w1_data", wb_wdata, 32'hAAAA0001);
        chk("full_cnt3", ld_cnt, 3);
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd5; ld_resp_data = 32'hBBBB0002; #1;
        chk("ovl_issue_ready", ld_issue_ready, 1);
        tick();
        ld_issue_valid = 1'b0;
        chk("ovl_cnt3", ld_cnt, 3);
        chk("ovl_w2_rd", wb_rd, 2);
        chk("ovl_w2_data", wb_wdata, 32'hBBBB0002);
        ld_resp_data = 32'hCCCC0003;
        tick();
        chk("drain_w3_rd", wb_rd, 3);
        chk("drain_w3_data", wb_wdata, 32'hCCCC0003);
        ld_resp_data = 32'hDDDD0004;
        tick();
        chk("drain_w4_rd", wb_rd, 4);
        chk("drain_w4_data", wb_wdata, 32'hDDDD0004);
        ld_resp_data = 32'hEEEE0005;
        tick();
        ld_resp_valid = 1'b0;
        chk("drain_w5_rd", wb_rd, 5);
        chk("drain_w5_data", wb_wdata, 32'hEEEE0005);
        chk("drain_cnt0", ld_cnt, 0);
        chk("drain_err", err, 0);

        // Response with nothing outstanding.
        ld_resp_valid = 1'b1; ld_resp_data = 32'h00000BAD; #1;
        chk("viol_resp_ready", ld_resp_ready, 0);
        tick();
        ld_resp_valid = 1'b0;
        chk("viol_resp_wen", wb_wen, 0);
        chk("viol_resp_err", err, 1);
        chk("viol_resp_wdata", wb_wdata, 32'hEEEE0005);
        tick();
        chk("err_sticky", err, 1);

        // Asynchronous reset with a load in flight.
        issue(5'd10);
        chk("arst_cnt_before", ld_cnt, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_cnt", ld_cnt, 0);
        chk("arst_err", err, 0);
        dec_rs1 = 5'd10; #1;
        chk("arst_hazard", dec_hazard, 0);
        dec_rs1 = 5'd0;
        #1 rst = 1'b1;
        tick();

        // ALU write to a register with a load outstanding.
        issue(5'd11);
        ld_issue_rd = 5'd11; #1;
        chk("busy_issue_ready", ld_issue_ready, 0);
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'h77;
        tick();
        alu_valid = 1'b0;
        chk("alu_busy_wen", wb_wen, 1);
        chk("alu_busy_rd", wb_rd, 11);
        chk("alu_busy_wdata", wb_wdata, 32'h77);
        chk("alu_busy_err", err, 1);
        chk("alu_busy_cnt", ld_cnt, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
